// File: rtl/alu_operand_stage.sv
// ID/EX operand register that feeds the ALU. Define ALU_OPERAND_STAGE_FWD_EN to
// enable the EX/MEM and MEM/WB forwarding muxes; otherwise the stage presents captured data.
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [15:0]   imm,
  input  logic          ext_sign,
  input  logic          alusrc,
  input  logic [4:0]    aluop_in,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic          regwrite_in,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [4:0]    ALUOp,
  output logic [RW-1:0] out_rd,
  output logic          out_regwrite,
  output logic [DW-1:0] store_data
);

  logic          valid_q,    valid_d;
  logic [DW-1:0] rs_q,       rs_d;
  logic [DW-1:0] rt_q,       rt_d;
  logic [DW-1:0] imm_ext_q,  imm_ext_d;
  logic          alusrc_q,   alusrc_d;
  logic [4:0]    aluop_q,    aluop_d;
  logic [RW-1:0] rs_addr_q,  rs_addr_d;
  logic [RW-1:0] rt_addr_q,  rt_addr_d;
  logic [RW-1:0] rd_q,       rd_d;
  logic          regwrite_q, regwrite_d;

  logic          capture;
  logic [DW-1:0] imm_ext;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign imm_ext  = ext_sign ? {{(DW-16){imm[15]}}, imm} : {{(DW-16){1'b0}}, imm};

  always_comb begin
    valid_d    = valid_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    imm_ext_d  = imm_ext_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;

    // Flush outranks capture and drain; stale data is harmless once valid drops.
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (capture) begin
      rs_d       = rs_data;
      rt_d       = rt_data;
      imm_ext_d  = imm_ext;
      alusrc_d   = alusrc;
      aluop_d    = aluop_in;
      rs_addr_d  = rs_addr;
      rt_addr_d  = rt_addr;
      rd_d       = rd_addr;
      regwrite_d = regwrite_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_ext_q  <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      imm_ext_q  <= imm_ext_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
    end
  end

  // Index 0 is the rs source, index 1 the rt source.
  logic [1:0][DW-1:0] src_data;
  logic [1:0][DW-1:0] fwd_data;

  assign src_data[0] = rs_q;
  assign src_data[1] = rt_q;

`ifdef ALU_OPERAND_STAGE_FWD_EN
  logic [1:0][RW-1:0] src_addr;

  assign src_addr[0] = rs_addr_q;
  assign src_addr[1] = rt_addr_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic exmem_hit;
      logic memwb_hit;

      // Register $0 is hardwired, so a producer naming rd 0 never forwards.
      assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_addr[gi]);
      assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_addr[gi]);
      assign fwd_data[gi] = exmem_hit ? exmem_result :
                            memwb_hit ? memwb_result : src_data[gi];
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nofwd
      assign fwd_data[gi] = src_data[gi];
    end
  endgenerate

  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result,
                        rs_addr_q, rt_addr_q};
`endif

  assign out_valid    = valid_q;
  assign A            = fwd_data[0];
  assign B            = alusrc_q ? imm_ext_q : fwd_data[1];
  assign store_data   = fwd_data[1];
  assign ALUOp        = aluop_q;
  assign out_rd       = rd_q;
  assign out_regwrite = regwrite_q && valid_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands, immediate and 5-bit ALUOp, then drives the ALU A, B and ALUOp inputs.
- Resolves EX/MEM and MEM/WB data hazards via forwarding muxes.
- Valid/ready handshake toward decode (upstream) and the EX consumer (downstream); supports flush for branch redirect.

Parameters:
- DW, 32, datapath width of operands and results
- RW, 5, register-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- rs_data  in  DW  register-file read port 1
- rt_data  in  DW  register-file read port 2
- imm  in  16  instruction immediate
- ext_sign  in  1  1 = sign-extend imm, 0 = zero-extend
- alusrc  in  1  1 = B from extended imm, 0 = B from rt
- aluop_in  in  5  ALU operation code
- rs_addr, rt_addr, rd_addr  in  RW  source/destination register numbers
- regwrite_in  in  1  instruction writes rd
- flush  in  1  kill the held instruction and any capture this cycle
- exmem_regwrite, exmem_rd, exmem_result  in  1/RW/DW  EX/MEM forward source
- memwb_regwrite, memwb_rd, memwb_result  in  1/RW/DW  MEM/WB forward source
- out_ready  in  1  ALU/EX consumer accepts
- out_valid  out  1  A/B/ALUOp hold a live instruction
- A, B  out  DW  ALU operands
- ALUOp  out  5  registered aluop_in
- out_rd  out  RW  registered rd_addr
- out_regwrite  out  1  registered regwrite_in AND out_valid
- store_data  out  DW  forwarded rt value, regardless of alusrc

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: out_valid=0; all captured registers 0 (so A=B=0, ALUOp=0, out_rd=0, out_regwrite=0, store_data=0 when no forward hits).
- Ready rule: in_ready = !out_valid || out_ready. Combinational, no dependency on in_valid.
- Capture: on edge with in_valid && in_ready && !flush, load all input fields; out_valid=1 next cycle. Latency is 1 cycle from accept to ALU presentation.
- Drain: on edge with out_valid && out_ready and no new capture, out_valid goes to 0.
- Back-to-back: accept while draining is allowed; throughput is 1 instr/cycle.
- Hold: out_valid && !out_ready means all registers stay frozen and in_ready=0.
- Flush: highest priority. On the next edge out_valid=0 and no capture, even if in_valid && in_ready. Captured data may remain stale but out_regwrite is forced 0.
- Reset mid-operation: reset beats flush and capture; state goes to the reset values.
- Immediate extension: ext_sign=1 gives {{16{imm[15]}},imm}, else {16'b0,imm}. Extension is computed at capture and stored as a DW register.
- Forwarding (combinational on registered addresses), for each source s in {rs, rt}:
  - if exmem_regwrite && exmem_rd!=0 && exmem_rd==s_addr_q, use exmem_result;
  - else if memwb_regwrite && memwb_rd!=0 && memwb_rd==s_addr_q, use memwb_result;
  - else use the captured data.
  - EX/MEM wins when both match.
- Operand mapping: A = fwd_rs; B = alusrc_q ? imm_ext_q : fwd_rt; store_data = fwd_rt.
- Register $0: never forwarded. A source address of 0 always yields the captured data, even if a forward source names rd 0.
- Hold stability: during a hold, forwarded values may change cycle-to-cycle as the downstream pipe advances. This is intended, so the ALU sees the newest producer.

Optional Feature:
- Macro: ALU_OPERAND_STAGE_FWD_EN
- Defined: forwarding muxes present, as described above.
- Undefined: forwarding removed. A = rs_q, B = alusrc_q ? imm_ext_q : rt_q, store_data = rt_q. The exmem_* and memwb_* ports remain but are ignored; the hazard stall becomes the decode stage's responsibility.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, A=B=0, ALUOp=0, in_ready=1 after release.
- Simple capture: rs_data=5, rt_data=7, alusrc=0, aluop_in=5'b00000, out_ready=1 -> next cycle out_valid=1, A=5, B=7, ALUOp=0.
- Immediate extension: imm=16'hFFFE, alusrc=1; ext_sign=1 -> B=32'hFFFFFFFE; ext_sign=0 -> B=32'h0000FFFE.
- Forward priority (FWD_EN defined): rs_addr=3; exmem_rd=3/result=0xAA; memwb_rd=3/result=0xBB; both regwrite=1 -> A=0xAA. Drop exmem_regwrite -> A=0xBB. rs_addr=0 with exmem_rd=0 -> A=captured rs_data.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen. out_ready=1 -> next instruction presented the following cycle with no loss or duplication.
- Flush: flush=1 concurrent with in_valid=1 while holding an instruction -> next cycle out_valid=0, out_regwrite=0. The new instruction is not captured.
